// File: rtl/sync_recover_if.sv
// Signal bundle between a sync-line source and the sync_recover timing-recovery block.
// TOTAL must match the TOTAL of the sync_recover instance it connects to.
interface sync_recover_if #(
    parameter int TOTAL = 800
);
    localparam int W = $clog2(TOTAL);

    logic                enable;
    logic                sync_in;
    logic                locked;
    logic                error;
    logic                blank;
    logic                active;
    logic signed [W:0]   counter;
    logic        [W+1:0] meas_period;
    logic        [W+1:0] meas_width;

    modport master (
        output enable, sync_in,
        input  locked, error, blank, active, counter, meas_period, meas_width
    );

    modport slave (
        input  enable, sync_in,
        output locked, error, blank, active, counter, meas_period, meas_width
    );
endinterface

// File: rtl/sync_recover.sv
// Sync-line receiver: measures pulse period/width, locks after LOCK_COUNT good lines and
// regenerates the signed position counter (negative = blanking, 0..RESOLUTION-1 = active).
module sync_recover #(
    parameter int RESOLUTION  = 640,
    parameter int FRONT_PORCH = 16,
    parameter int SYNC_PULSE  = 96,
    parameter int BACK_PORCH  = 48,
    parameter int TOTAL       = 800,
    parameter int LOCK_COUNT  = 4,
    parameter bit SYNC_POL    = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    sync_recover_if.slave  bus
);
    localparam int W  = $clog2(TOTAL);
    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic signed [W:0] CNT_START  = (W+1)'(-(FRONT_PORCH + SYNC_PULSE + BACK_PORCH));
    localparam logic signed [W:0] CNT_RELOAD = (W+1)'(1 - SYNC_PULSE - BACK_PORCH);
    localparam logic signed [W:0] CNT_LAST   = (W+1)'(RESOLUTION - 1);
    localparam logic signed [W:0] CNT_ONE    = (W+1)'(1);

    localparam logic [W+1:0] MEAS_ONE   = (W+2)'(1);
    localparam logic [W+1:0] MEAS_MAX   = (W+2)'(2 * TOTAL);
    localparam logic [W+1:0] TIMEOUT_AT = (W+2)'(2 * TOTAL - 1);
    localparam logic [W+1:0] MEAS_TOTAL = (W+2)'(TOTAL);
    localparam logic [W+1:0] MEAS_SYNC  = (W+2)'(SYNC_PULSE);

    localparam logic [GW-1:0] GOOD_ONE    = GW'(1);
    localparam logic [GW-1:0] LOCK_TARGET = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [W+1:0] sat_inc(input logic [W+1:0] v);
        return (v >= MEAS_MAX) ? MEAS_MAX : v + MEAS_ONE;
    endfunction

    function automatic logic signed [W:0] next_pos(input logic signed [W:0] c);
        return (c == CNT_LAST) ? CNT_START : c + CNT_ONE;
    endfunction

    state_t                state;
    state_t                state_nxt;
    logic [GW-1:0]         good_cnt;
    logic [GW-1:0]         good_nxt;
    logic [GW-1:0]         good_inc;
    logic                  error_nxt;
    logic                  error;
    logic                  s_prev;
    logic [W+1:0]          period_cnt;
    logic [W+1:0]          width_cnt;
    logic [W+1:0]          meas_period;
    logic [W+1:0]          meas_width;
    logic signed [W:0]     counter;

    logic s;
    logic tick;
    logic rise;
    logic fall;
    logic timeout;
    logic good_line;
    logic locked;

    assign s         = SYNC_POL ? bus.sync_in : ~bus.sync_in;
    assign tick      = bus.enable;
    assign rise      = tick & s & ~s_prev;
    assign fall      = tick & ~s & s_prev;
    // A rise always takes precedence over the period timeout.
    assign timeout   = tick & ~rise & (period_cnt == TIMEOUT_AT);
    assign good_line = (period_cnt == MEAS_TOTAL) && (meas_width == MEAS_SYNC);
    assign good_inc  = good_cnt + GOOD_ONE;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        error_nxt = 1'b0;
        case (state)
            HUNT: begin
                good_nxt = '0;
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (good_line) begin
                        good_nxt = good_inc;
                        if (good_inc == LOCK_TARGET) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end else if (timeout) begin
                    state_nxt = HUNT;
                    good_nxt  = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (!good_line) begin
                        state_nxt = MEASURE;
                        good_nxt  = '0;
                        error_nxt = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = HUNT;
                    good_nxt  = '0;
                    error_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = HUNT;
                good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= HUNT;
            good_cnt <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            error    <= error_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_prev      <= 1'b0;
            period_cnt  <= '0;
            width_cnt   <= '0;
            meas_period <= '0;
            meas_width  <= '0;
        end else begin
            if (tick) begin
                s_prev <= s;
            end
            if (rise) begin
                period_cnt <= MEAS_ONE;
            end else if (tick) begin
                period_cnt <= sat_inc(period_cnt);
            end
            if (rise) begin
                width_cnt <= MEAS_ONE;
            end else if (tick && s && s_prev) begin
                width_cnt <= sat_inc(width_cnt);
            end
            if (fall) begin
                meas_width <= width_cnt;
            end
            if (rise && state != HUNT) begin
                meas_period <= period_cnt;
            end
        end
    end

    // Reload on rise so the counter matches the generator with zero latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= CNT_START;
        end else if (rise) begin
            counter <= CNT_RELOAD;
        end else if (tick) begin
            if (state == HUNT || timeout) begin
                counter <= CNT_START;
            end else begin
                counter <= next_pos(counter);
            end
        end
    end

    assign locked          = (state == LOCKED);
    assign bus.locked      = locked;
    assign bus.error       = error;
    assign bus.blank       = ~locked | counter[W];
    assign bus.active      = locked & ~counter[W];
    assign bus.counter     = counter;
    assign bus.meas_period = meas_period;
    assign bus.meas_width  = meas_width;
endmodule
